instr_prefetch_queue: RTL and testbench
=======================================

Name: instr_prefetch_queue

Overview:
- Parametrised successor to the single-slot instruction fetch front end.
- Fetches raw instruction words from block instruction memory (1-cycle read latency) and skips NOPs.
- Buffers fetched words in a prefetch FIFO of configurable depth, tagged with block index; presents them to the decode stage over valid/ready.
- New behaviour:
  - optional frame mode: one pass over blocks 0..last_block per sample_tick, with frame_done and overrun reporting;
  - synchronous flush.

Parameters:
instr_width, 32, instruction word width; opcode is bits [4:0]
n_blocks, 256, block count; block index width is $clog2(n_blocks)
depth, 4, prefetch FIFO entries; power of two, at least 2

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
enable  in  1  gates new memory reads only
flush  in  1  discard queue and in-flight read, restart at block 0
frame_mode  in  1  0 = free-running wrap; 1 = one pass per sample_tick
sample_tick  in  1  frame start strobe
n_blocks_running  in  $clog2(n_blocks)  0 stops issuing
last_block  in  $clog2(n_blocks)  wrap point
instr_read_addr  out  $clog2(n_blocks)  memory read address
instr_read_val  in  instr_width  data for the address issued the previous cycle
out_valid  out  1  queue head valid
out_ready  in  1  consumer accepts the head
instr_out  out  instr_width  head instruction word
block_out  out  $clog2(n_blocks)  head block index
frame_done  out  1  1-cycle pulse when the last_block read returns (frame mode)
tick_overrun  out  1  1-cycle pulse on sample_tick while a tick is already pending
level  out  $clog2(depth)+1  current FIFO occupancy

Behaviour:
- Reset values:
  - instr_read_addr = 0, level = 0, out_valid = 0;
  - frame_done = 0, tick_overrun = 0;
  - in-flight flag = 0, tick_pending = 0;
  - state = RUN.
- Reset and flush both override all other activity in the same cycle.
- States:
  - RUN: issuing reads.
  - WAIT_TICK: frame mode only, frame complete, no issue.
- Issue condition, evaluated each cycle: enable && state == RUN && n_blocks_running != 0 && (level + inflight) < depth.
  - Back-to-back issue every cycle is allowed while credit remains.
- On issue:
  - the address is tagged into the in-flight register;
  - instr_read_addr advances to (addr == last_block) ? 0 : addr + 1.
  - If frame_mode && addr == last_block, the state goes to WAIT_TICK.
- Return (cycle after issue):
  - if instr_read_val[4:0] == `BLOCK_INSTR_NOP, the word is dropped;
  - otherwise {word, tag} is pushed;
  - if frame_mode && tag == last_block, frame_done pulses in that cycle, whether the word was dropped or pushed.
- Returns complete even if enable has fallen since issue.
- Pop: out_valid = (level != 0); head pops when out_valid && out_ready.
- Push and pop in the same cycle leave level unchanged. The credit rule makes overflow impossible.
- Output data: instr_out/block_out show the head combinationally from registered FIFO storage. The head is stable while out_valid && !out_ready.
- sample_tick handling:
  - sets tick_pending; if tick_pending is already 1, tick_overrun pulses instead.
  - In WAIT_TICK with tick_pending = 1: next cycle is RUN at addr 0, tick_pending cleared.
  - A tick in the same cycle as the last_block issue is valid (it is pending) and restarts the frame immediately after.
- frame_mode = 0: sample_tick is ignored (no pending, no overrun) and WAIT_TICK is never entered. If frame_mode falls while in WAIT_TICK, the state returns to RUN next cycle.
- flush:
  - level := 0, the in-flight return is discarded, addr := 0;
  - state := RUN, tick_pending := 0.
- n_blocks_running == 0: issue stops; the in-flight read completes; the queue drains normally.
- last_block changed mid-pass: used at the next wrap compare. If addr is already above last_block, it wraps when it reaches n_blocks-1.
- Memory is read-only from this block; no write ports.

Decomposition:
- `BLOCK_INSTR_NOP and the opcode field position come from the shared instr_dec.vh.
- Add QUEUE state encodings (RUN, WAIT_TICK) to core.vh.
- One natural sub-module: sync_fifo_fwft, parametrised by width and depth, with a level output. Here it is instantiated with width instr_width + $clog2(n_blocks).
- The decoder stays downstream and is not instantiated here.

Test Plan:
- Free-run, last_block = 3, no NOPs, out_ready = 1: output blocks 0,1,2,3,0,1… at one word per cycle after 2-cycle startup latency.
- Block 1 opcode = NOP, last_block = 3: output block sequence 0,2,3,0,2; no bubble in addr issue.
- depth = 4, out_ready = 0: issue stops with level = 4 and no word lost. Raise out_ready: words 0..3 emerge in order, then fetch resumes at block 4 mod wrap.
- frame_mode = 1, last_block = 2, tick at cycle 0: blocks 0,1,2 emitted; frame_done pulses once; no issue until next tick. A second tick before completion pulses tick_overrun.
- Flush while level = 3 and a read is in flight: level = 0 next cycle, the in-flight word is not emitted, the next output is block 0.
- Reset asserted mid-stream with out_ready = 0: all outputs return to reset values next cycle, and fetch restarts at block 0 after deassertion.

Source files
------------

// File: rtl/instr_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: opcode field, NOP encoding, queue states.
package instr_prefetch_queue_pkg;

  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 5;
  localparam logic [OPC_W-1:0] BLOCK_INSTR_NOP = 5'h13;

  typedef enum logic [0:0] {
    Q_RUN       = 1'b0,
    Q_WAIT_TICK = 1'b1
  } queue_state_e;

  function automatic logic is_nop(input logic [OPC_W-1:0] opc);
    return opc == BLOCK_INSTR_NOP;
  endfunction

endpackage

// File: rtl/instr_prefetch_queue_sync_fifo_fwft.sv
// First-word-fall-through FIFO: head visible combinationally from registered storage.
// Pushes beyond capacity are the caller's responsibility; clear and reset empty the queue.
module sync_fifo_fwft #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [width-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic                     o_vld,
  output logic [width-1:0]         o_head_dat,
  output logic [$clog2(depth):0]   o_level
);
  localparam int AW = $clog2(depth);

  logic [width-1:0] r_mem [depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_pop;

  assign w_do_pop   = i_pop && (r_level != '0);
  assign o_vld      = (r_level != '0);
  assign o_level    = r_level;
  assign o_head_dat = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + (AW+1)'(i_push) - (AW+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !reset && !i_clear) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch: issues block reads under credit, drops NOP returns, queues {word, block}.
// Optional frame mode runs one pass per sample_tick; flush and reset discard queue and in-flight read.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int instr_width = 32,
  parameter int n_blocks    = 256,
  parameter int depth       = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        flush,
  input  logic                        frame_mode,
  input  logic                        sample_tick,
  input  logic [$clog2(n_blocks)-1:0] n_blocks_running,
  input  logic [$clog2(n_blocks)-1:0] last_block,
  output logic [$clog2(n_blocks)-1:0] instr_read_addr,
  input  logic [instr_width-1:0]      instr_read_val,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [instr_width-1:0]      instr_out,
  output logic [$clog2(n_blocks)-1:0] block_out,
  output logic                        frame_done,
  output logic                        tick_overrun,
  output logic [$clog2(depth):0]      level
);
  localparam int AW = $clog2(n_blocks);
  localparam int LW = $clog2(depth) + 1;
  localparam int FW = instr_width + AW;

  queue_state_e  r_state;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_tag;
  logic          r_inflight;
  logic          r_tick_pending;

  logic [LW:0]   w_used;
  logic          w_issue;
  logic          w_push;
  logic          w_restart;
  logic [AW-1:0] w_next_addr;
  logic [FW-1:0] w_head;

  // Credit counts the in-flight read so a return always has a free slot.
  assign w_used      = {1'b0, level} + {{LW{1'b0}}, r_inflight};
  assign w_issue     = enable && (r_state == Q_RUN) && (n_blocks_running != '0)
                       && (w_used < (LW+1)'(depth));
  assign w_next_addr = (r_addr == last_block || r_addr == AW'(n_blocks - 1)) ? '0 : r_addr + 1'b1;
  assign w_push      = r_inflight && !flush && !is_nop(instr_read_val[OPC_LSB +: OPC_W]);
  assign w_restart   = (r_state == Q_WAIT_TICK) && frame_mode && r_tick_pending;

  assign instr_read_addr = r_addr;
  assign frame_done      = r_inflight && frame_mode && (r_tag == last_block) && !flush && !reset;
  assign tick_overrun    = frame_mode && sample_tick && r_tick_pending && !flush && !reset;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state        <= Q_RUN;
      r_addr         <= '0;
      r_tag          <= '0;
      r_inflight     <= 1'b0;
      r_tick_pending <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_tag <= r_addr;
      if (w_restart)                      r_tick_pending <= 1'b0;
      else if (frame_mode && sample_tick) r_tick_pending <= 1'b1;
      case (r_state)
        Q_RUN: begin
          if (w_issue) begin
            r_addr <= w_next_addr;
            if (frame_mode && r_addr == last_block) r_state <= Q_WAIT_TICK;
          end
        end
        Q_WAIT_TICK: begin
          if (!frame_mode) begin
            r_state <= Q_RUN;
          end else if (r_tick_pending) begin
            r_state <= Q_RUN;
            r_addr  <= '0;
          end
        end
        default: r_state <= Q_RUN;
      endcase
    end
  end

  sync_fifo_fwft #(
    .width (FW),
    .depth (depth)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (flush),
    .i_push     (w_push),
    .i_push_dat ({instr_read_val, r_tag}),
    .i_pop      (out_ready),
    .o_vld      (out_valid),
    .o_head_dat (w_head),
    .o_level    (level)
  );

  assign instr_out = w_head[FW-1:AW];
  assign block_out = w_head[AW-1:0];

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboarded bench: expected {word, block} stream derived from memory contents and wrap rules.
module tb_instr_prefetch_queue;
  import instr_prefetch_queue_pkg::*;

  localparam int W  = 32;
  localparam int NB = 16;
  localparam int D  = 4;
  localparam int AW = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset, enable, flush, frame_mode, sample_tick, out_ready;
  logic [AW-1:0] n_blocks_running, last_block, instr_read_addr, block_out;
  logic [W-1:0]  instr_read_val, instr_out;
  logic          out_valid, frame_done, tick_overrun;
  logic [LW-1:0] level;

  instr_prefetch_queue #(.instr_width(W), .n_blocks(NB), .depth(D)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .frame_mode(frame_mode), .sample_tick(sample_tick),
    .n_blocks_running(n_blocks_running), .last_block(last_block),
    .instr_read_addr(instr_read_addr), .instr_read_val(instr_read_val),
    .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
    .block_out(block_out), .frame_done(frame_done), .tick_overrun(tick_overrun),
    .level(level)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [NB];
  always @(posedge clk) instr_read_val <= mem[instr_read_addr];

  typedef struct {
    logic [W-1:0]  w;
    logic [AW-1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  int   n_fd     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void fill_mem(input int nop_pct);
    for (int i = 0; i < NB; i++) begin
      logic [W-1:0] w;
      w = $urandom;
      if (int'($urandom_range(0, 99)) < nop_pct) w[4:0] = BLOCK_INSTR_NOP;
      else if (w[4:0] == BLOCK_INSTR_NOP)        w[4:0] = BLOCK_INSTR_NOP ^ 5'h01;
      mem[i] = w;
    end
  endfunction

  // Reference: walk block indices in issue order, keep the non-NOP words.
  function automatic void push_seq(input int start, input int lb, input int issues);
    int a;
    exp_t e;
    a = start;
    for (int i = 0; i < issues; i++) begin
      if (mem[a][4:0] != BLOCK_INSTR_NOP) begin
        e.w = mem[a];
        e.b = a[AW-1:0];
        exp_q.push_back(e);
      end
      a = (a == lb || a == NB - 1) ? 0 : a + 1;
    end
  endfunction

  task automatic hold_reset();
    reset = 1'b1; enable = 1'b0; flush = 1'b0; sample_tick = 1'b0; out_ready = 1'b0;
    frame_mode = 1'b0; n_blocks_running = 4'd15; last_block = 4'd3;
    step(2);
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_level"}, 64'(level), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_addr"}, 64'(instr_read_addr), 64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_tick_overrun"}, 64'(tick_overrun), 64'd0);
  endtask

  // Monitor: pops on every accepted head, and checks the head holds while stalled.
  exp_t          m_e;
  logic          p_hold = 1'b0;
  logic [W+AW-1:0] p_dat;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && !flush) begin
        if (frame_done) n_fd++;
        if (p_hold) check("head_stable", 64'({out_valid, instr_out, block_out}), 64'({1'b1, p_dat}));
        if (out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            check("unexpected_output", 64'({instr_out, block_out}), 64'hDEAD);
          end else begin
            m_e = exp_q.pop_front();
            check("out_word_block", 64'({instr_out, block_out}), 64'({m_e.w, m_e.b}));
          end
        end
        p_hold = out_valid && !out_ready;
        p_dat  = {instr_out, block_out};
      end else begin
        p_hold = 1'b0;
      end
    end
  end

  initial begin
    int base, cnt, fd0;
    logic [AW-1:0] a_hold;

    // Reset values and free-run startup latency
    hold_reset();
    check_reset_vals("reset");
    fill_mem(0);
    push_seq(0, 3, 200);
    out_ready = 1'b1; enable = 1'b1; reset = 1'b0;
    base = n_out;
    step; check("latency_c1_valid", 64'(out_valid), 64'd0);
    step; check("latency_c2_valid", 64'(out_valid), 64'd1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin step; if (out_valid) cnt++; end
    check("freerun_one_per_cycle", 64'(cnt), 64'd10);
    sample_tick = 1'b1; step; #1;
    check("tick_ignored_free_run", 64'(tick_overrun), 64'd0);
    sample_tick = 1'b0;
    step(5);
    check("freerun_outputs", 64'(n_out - base >= 15), 64'd1);

    // NOP in block 1: issue keeps stepping every cycle
    hold_reset();
    fill_mem(0);
    mem[1][4:0] = BLOCK_INSTR_NOP;
    push_seq(0, 3, 200);
    out_ready = 1'b1; enable = 1'b1; reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step;
      check("nop_addr_no_bubble", 64'(instr_read_addr), 64'(k % 4));
    end
    step(10);

    // Backpressure: queue fills to depth, nothing lost
    hold_reset();
    fill_mem(0);
    push_seq(0, 3, 200);
    enable = 1'b1; reset = 1'b0;
    step(10);
    check("stall_level_full", 64'(level), 64'(D));
    check("stall_addr", 64'(instr_read_addr), 64'd0);
    base = n_out;
    out_ready = 1'b1;
    step(30);
    check("stall_resume_outputs", 64'(n_out - base >= 25), 64'd1);

    // last_block lowered below current address: wraps at n_blocks-1
    hold_reset();
    fill_mem(0);
    last_block = 4'd10; enable = 1'b1; reset = 1'b0;
    step(10);
    check("lb_change_addr", 64'(instr_read_addr), 64'd4);
    last_block = 4'd2;
    push_seq(0, 10, 4);
    push_seq(4, 2, 200);
    base = n_out;
    out_ready = 1'b1;
    step(40);
    check("lb_change_outputs", 64'(n_out - base >= 35), 64'd1);

    // n_blocks_running = 0: issue stops, queue drains
    n_blocks_running = 4'd0;
    step(10);
    check("nbr0_level", 64'(level), 64'd0);
    check("nbr0_valid", 64'(out_valid), 64'd0);
    a_hold = instr_read_addr;
    step(5);
    check("nbr0_addr_frozen", 64'(instr_read_addr), 64'(a_hold));
    n_blocks_running = 4'd15;
    base = n_out;
    step(20);
    check("nbr_resume_outputs", 64'(n_out - base >= 15), 64'd1);

    // Flush with level 3 and a read in flight
    hold_reset();
    fill_mem(0);
    last_block = 4'd7; enable = 1'b1; reset = 1'b0;
    for (int k = 0; k < 10 && level != 3'd3; k++) step;
    check("flush_setup_level", 64'(level), 64'd3);
    flush = 1'b1;
    step;
    flush = 1'b0;
    check("flush_level", 64'(level), 64'd0);
    check("flush_addr", 64'(instr_read_addr), 64'd0);
    push_seq(0, 7, 200);
    base = n_out;
    out_ready = 1'b1;
    step(20);
    check("flush_outputs", 64'(n_out - base >= 15), 64'd1);

    // Reset mid-stream with consumer stalled
    out_ready = 1'b0;
    step(6);
    reset = 1'b1;
    step;
    check_reset_vals("midreset");
    exp_q.delete();
    push_seq(0, 7, 200);
    reset = 1'b0; out_ready = 1'b1;
    base = n_out;
    step(20);
    check("midreset_outputs", 64'(n_out - base >= 15), 64'd1);

    // Frame mode: one pass, then tick handling
    hold_reset();
    fill_mem(0);
    frame_mode = 1'b1; last_block = 4'd2;
    push_seq(0, 2, 3);
    fd0 = n_fd; base = n_out;
    out_ready = 1'b1; enable = 1'b1; reset = 1'b0;
    step(20);
    check("frame1_done_pulses", 64'(n_fd - fd0), 64'd1);
    check("frame1_outputs", 64'(n_out - base), 64'd3);
    check("frame1_idle_addr", 64'(instr_read_addr), 64'd0);
    push_seq(0, 2, 6);
    fd0 = n_fd; base = n_out;
    sample_tick = 1'b1;
    step; #1;
    check("tick_overrun_pulse", 64'(tick_overrun), 64'd1);
    step; sample_tick = 1'b0;
    step;
    step; sample_tick = 1'b1; #1;
    check("tick_on_last_issue_no_overrun", 64'(tick_overrun), 64'd0);
    step; sample_tick = 1'b0;
    step(25);
    check("frame2_done_pulses", 64'(n_fd - fd0), 64'd2);
    check("frame2_outputs", 64'(n_out - base), 64'd6);
    check("frame2_queue_drained", 64'(exp_q.size()), 64'd0);

    // Randomized free-run: NOPs, last_block, enable and out_ready all random
    for (int r = 0; r < 4; r++) begin
      int lb;
      hold_reset();
      fill_mem(25);
      mem[0][4:0] = BLOCK_INSTR_NOP ^ 5'h02;
      lb = int'($urandom_range(0, NB - 1));
      last_block = lb[AW-1:0];
      push_seq(0, lb, 200);
      base = n_out;
      reset = 1'b0;
      for (int k = 0; k < 150; k++) begin
        out_ready = ($urandom_range(0, 9) < 7);
        enable    = ($urandom_range(0, 3) != 0);
        step;
      end
      check("random_outputs_seen", 64'(n_out - base > 0), 64'd1);
    end

    out_ready = 1'b0;
    step(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
